aes_req_arbiter: RTL

- Shares one AES-128 encryption core (aes_modified) between NUM_REQ independent requesters.
- Accepts one plaintext/key pair at a time under round-robin arbitration and drives the core's start/in/encrypkey.
- Times the core's fixed latency, captures the ciphertext and returns it to the owning requester with a valid/ready handshake.
- Sits between bus-side requesters (DMA, CPU mailbox) and the core instance; the core shares clk/rst with this block.

---
 rtl/aes_ctrl_pkg.sv | 20 ++
 rtl/aes_req_arbiter_if.sv | 33 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/aes_req_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared types, constants and helpers for the AES request path
// Contents: arb_state_t (arbiter FSM states), AES_BLK_W, AES_CORE_LATENCY,
//           idx_w() (index width for an N-entry vector, never below 1 bit).
package aes_ctrl_pkg;

    localparam int AES_BLK_W        = 128;
    localparam int AES_CORE_LATENCY = 41;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_req_arbiter_if.sv
// rtl/aes_req_arbiter_if.sv - requester-side request/response bundle of the AES arbiter
// Signals: req_valid/req_ready/req_data/req_key (request, one slice per requester),
//          resp_valid/resp_ready/resp_data (ciphertext return), busy, owner.
// Modports: master = requester side, slave = arbiter side.
interface aes_req_arbiter_if
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BLK_W   = AES_BLK_W
);
    localparam int IW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*BLK_W-1:0] req_data;
    logic [NUM_REQ*BLK_W-1:0] req_key;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [BLK_W-1:0]         resp_data;
    logic                     busy;
    logic [IW-1:0]            owner;

    modport master (
        output req_valid, req_data, req_key, resp_ready,
        input  req_ready, resp_valid, resp_data, busy, owner
    );

    modport slave (
        input  req_valid, req_data, req_key, resp_ready,
        output req_ready, resp_valid, resp_data, busy, owner
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant over N request lines
// Ports: req (request vector), ptr (highest-priority index),
//        grant (one-hot or zero), grant_idx (index of the granted line, 0 when none).
module rr_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [N-1:0] cand;
    int           pos;

    // Walk the ring starting at ptr; the first requesting line wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        pos       = 0;
        for (int k = 0; k < N; k++) begin
            pos  = (int'(ptr) + k) % N;
            cand = N'(1) << pos;
            if (grant == '0 && (req & cand) != '0) begin
                grant     = cand;
                grant_idx = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// rtl/aes_req_arbiter.sv - shares one AES-128 core between NUM_REQ requesters
// Ports: clk, rst (async, active high); bus (aes_req_arbiter_if.slave: request and
//        response handshakes, busy, owner); core_start/core_in/core_key drive the core,
//        core_out returns its ciphertext.
module aes_req_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CORE_LATENCY = AES_CORE_LATENCY,
    parameter int BLK_W        = AES_BLK_W
) (
    input  logic             clk,
    input  logic             rst,
    aes_req_arbiter_if.slave bus,
    output logic             core_start,
    output logic [BLK_W-1:0] core_in,
    output logic [BLK_W-1:0] core_key,
    input  logic [BLK_W-1:0] core_out
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = $clog2(CORE_LATENCY + 1);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      owner_q;
    logic [CW-1:0]      cnt_q;
    logic [NUM_REQ-1:0] resp_valid_q;
    logic [BLK_W-1:0]   resp_data_q;
    logic [BLK_W-1:0]   core_in_q;
    logic [BLK_W-1:0]   core_key_q;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic [BLK_W-1:0]   sel_data;
    logic [BLK_W-1:0]   sel_key;
    logic               accept;
    logic               resp_fire;
    logic               busy_c;
    logic [NUM_REQ-1:0] req_ready_c;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data = '0;
        sel_key  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = bus.req_data[i*BLK_W +: BLK_W];
                sel_key  = bus.req_key[i*BLK_W +: BLK_W];
            end
        end
    end

    assign accept    = (state == IDLE) && (grant != '0);
    // resp_valid_q only ever carries the owner's bit, so other ready lines drop out here.
    assign resp_fire = (resp_valid_q & bus.resp_ready) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (cnt_q == '0) state_nxt = DELIVER;
            DELIVER: if (resp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_start  = 1'b0;
        busy_c      = 1'b1;
        req_ready_c = '0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                // Keep the accept strobe quiet while reset is held, even in IDLE.
                if (!rst) req_ready_c = grant;
            end
            LAUNCH:  core_start = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers. core_in/core_key are deliberately left holding the
    // last request once the operation completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            core_in_q    <= '0;
            core_key_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        core_in_q  <= sel_data;
                        core_key_q <= sel_key;
                        owner_q    <= grant_idx;
                    end
                end
                LAUNCH: begin
                    // The core samples start at the end of this cycle; counting
                    // down from LATENCY-1 lands on zero in its result cycle.
                    cnt_q <= CW'(CORE_LATENCY - 1);
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        resp_data_q  <= core_out;
                        resp_valid_q <= NUM_REQ'(1) << owner_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DELIVER: begin
                    if (resp_fire) begin
                        resp_valid_q <= '0;
                        ptr_q        <= (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = busy_c;
    assign bus.owner      = owner_q;
    assign core_in        = core_in_q;
    assign core_key       = core_key_q;

endmodule
